bmem_arbiter: RTL and testbench
===============================

// Module: bmem_arbiter
// PURPOSE
// Parametrised N-port arbiter and cacheline adapter between the cache dfp ports
// (I-cache, D-cache, later prefetcher) and the single banked-memory (bmem) port.
// It replaces the single-requester fetch path and the separate read-only line adapter.
// It grants one line request at a time, round-robin, and splits or gathers the line
// into bus beats for both reads and writes.
// PARAMETERS
// N_PORTS    2    number of dfp requesters (>=1)
// LINE_BITS  256  cacheline width
// BUS_BITS   64   bmem data width; BEATS = LINE_BITS/BUS_BITS (>=2)
// PORTS
// clk         in   1                   clock
// rst         in   1                   synchronous, active-high reset
// dfp_addr    in   N_PORTS*32          per-port line address, port i at [32i+:32]
// dfp_read    in   N_PORTS             per-port read request, level, held until resp
// dfp_write   in   N_PORTS             per-port write request, level, held until resp
// dfp_wdata   in   N_PORTS*LINE_BITS   per-port write line
// dfp_rdata   out  LINE_BITS           read line, broadcast; valid when dfp_resp bit set
// dfp_resp    out  N_PORTS             one-hot, 1-cycle completion pulse
// bmem_addr   out  32                  line-aligned address {addr[31:5],5'b0}
// bmem_read   out  1                   read command
// bmem_write  out  1                   write command / beat valid
// bmem_wdata  out  BUS_BITS            write beat
// bmem_ready  in   1                   memory accepts command/beat this cycle
// bmem_raddr  in   32                  address of returning beat (unused, lint-sunk)
// bmem_rdata  in   BUS_BITS            read beat
// bmem_rvalid in   1                   read beat valid
// BEHAVIOUR
// - Reset: state IDLE; all outputs 0; beat counter 0; last_grant = N_PORTS-1, so port 0 wins first.
// - FSM states: IDLE, RD_CMD, RD_DATA, WR_DATA, RESP.
// - IDLE: request_i = dfp_read[i] | dfp_write[i]. Scan ports from (last_grant+1) mod N.
//   Grant the first requester found. Latch grant, address, write line and op.
//   Go to WR_DATA if dfp_write is set, else RD_CMD. With no requester, stay in IDLE.
// - read+write on the same port is a protocol error. The block serves it as a write,
//   and a simulation assertion fires.
// - RD_CMD: bmem_read=1, bmem_addr=latched. Move to RD_DATA in the cycle bmem_ready=1.
// - RD_DATA: bmem_read=0. Each bmem_rvalid stores bmem_rdata at [BUS_BITS*k+:BUS_BITS]
//   and increments k; beat 0 is the LSBs. After beat BEATS-1 is stored, go to RESP.
// - WR_DATA: bmem_write=1, bmem_addr=latched, bmem_wdata=line beat k.
//   k advances only on a bmem_ready=1 cycle; beats are held while ready=0.
//   After beat BEATS-1 is accepted, go to RESP.
// - RESP: exactly one cycle. dfp_resp[grant]=1 and dfp_rdata=assembled line (reads).
//   For writes dfp_rdata keeps its previous value. Set last_grant=grant, clear k, go to IDLE.
//   A new grant is possible no earlier than the cycle after RESP.
// - Read latency is at least 1 (RD_CMD) + BEATS + 1 (RESP) cycles.
//   Write latency is at least BEATS + 1 cycles.
// - bmem_rvalid outside RD_DATA is ignored. Requests must not drop while granted;
//   a dropped request still completes and still pulses resp.
// - Ungranted requesters see no response and wait; with continuous requests,
//   round-robin bounds the wait to N_PORTS-1 transactions.
// - Reset in any state: next cycle is IDLE with outputs 0. A partial line is discarded
//   and no dfp_resp is issued.
// - k width = $clog2(BEATS). k wraps to 0 after the last beat.
// TESTING
// - Port0 read 0x1eceb000, memory returns beats A0..A3 -> bmem_read pulses 1 cycle (ready=1).
//   dfp_resp=2'b01 one cycle after A3, dfp_rdata={A3,A2,A1,A0}.
// - Ports 0 and 1 hold reads continuously for 4 transactions -> grants 0,1,0,1.
//   dfp_resp never has 2 bits set.
// - Port1 write line W with bmem_ready low for 3 cycles on beat 2 -> bmem_wdata=W[191:128]
//   is held for those cycles. Exactly 4 accepted beats, then dfp_resp=2'b10.
// - Read at 0x1eceb014 -> bmem_addr=0x1eceb000.
// - rst asserted in RD_DATA after 2 beats -> next cycle all outputs 0.
//   A following read returns a clean, correct line.
// - bmem_rvalid pulses while IDLE and during WR_DATA -> no state change.
//   The following read data is uncorrupted.

Source files
------------

// File: rtl/bmem_arbiter.sv
// Round-robin N-port cacheline arbiter and line/beat adapter for the bmem port.
// Serves one line read or write at a time and pulses a one-hot dfp_resp on completion.
module bmem_arbiter #(
   parameter int N_PORTS   = 2,
   parameter int LINE_BITS = 256,
   parameter int BUS_BITS  = 64
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [N_PORTS*32-1:0]        dfp_addr,
   input  logic [N_PORTS-1:0]           dfp_read,
   input  logic [N_PORTS-1:0]           dfp_write,
   input  logic [N_PORTS*LINE_BITS-1:0] dfp_wdata,
   output logic [LINE_BITS-1:0]         dfp_rdata,
   output logic [N_PORTS-1:0]           dfp_resp,
   output logic [31:0]                  bmem_addr,
   output logic                         bmem_read,
   output logic                         bmem_write,
   output logic [BUS_BITS-1:0]          bmem_wdata,
   input  logic                         bmem_ready,
   input  logic [31:0]                  bmem_raddr,
   input  logic [BUS_BITS-1:0]          bmem_rdata,
   input  logic                         bmem_rvalid
);

   localparam int BEATS = LINE_BITS / BUS_BITS;
   localparam int KW    = $clog2(BEATS);
   localparam int GW    = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
   localparam logic [31:0] LMASK = 32'(LINE_BITS / 8 - 1);
   localparam logic [KW-1:0] KLAST = KW'(BEATS - 1);

   typedef enum logic [2:0] {
      IDLE, RD_CMD, RD_DATA, WR_DATA, RESP
   } state_t;

   state_t               state_q, state_d;
   logic [GW-1:0]        grant_q, last_q;
   logic [31:0]          addr_q;
   logic [LINE_BITS-1:0] wline_q, line_q;
   logic [KW-1:0]        k_q;
   logic                 k_last;

   logic [N_PORTS-1:0]   req;
   logic                 found;
   logic [GW-1:0]        pick;
   logic [31:0]          pick_addr;
   logic [LINE_BITS-1:0] pick_wdata;
   logic                 pick_wr;
   int                   idx;

   logic unused_raddr;
   assign unused_raddr = ^bmem_raddr;

   assign req    = dfp_read | dfp_write;
   assign k_last = (k_q == KLAST);

   // Scan starts one past the previous winner.
   always_comb begin
      found      = 1'b0;
      pick       = '0;
      pick_addr  = '0;
      pick_wdata = '0;
      pick_wr    = 1'b0;
      idx        = 0;
      for (int j = 1; j <= N_PORTS; j++) begin
         idx = (int'(last_q) + j) % N_PORTS;
         if (!found && req[idx]) begin
            found      = 1'b1;
            pick       = GW'(idx);
            pick_addr  = dfp_addr[idx*32 +: 32];
            pick_wdata = dfp_wdata[idx*LINE_BITS +: LINE_BITS];
            pick_wr    = dfp_write[idx];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (found) state_d = pick_wr ? WR_DATA : RD_CMD;
         RD_CMD:  if (bmem_ready) state_d = RD_DATA;
         RD_DATA: if (bmem_rvalid && k_last) state_d = RESP;
         WR_DATA: if (bmem_ready && k_last) state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         grant_q <= '0;
         last_q  <= GW'(N_PORTS - 1);
         addr_q  <= '0;
         wline_q <= '0;
         line_q  <= '0;
         k_q     <= '0;
      end else begin
         case (state_q)
            IDLE: if (found) begin
               grant_q <= pick;
               addr_q  <= pick_addr & ~LMASK;
               wline_q <= pick_wdata;
            end
            RD_DATA: if (bmem_rvalid) begin
               line_q[int'(k_q)*BUS_BITS +: BUS_BITS] <= bmem_rdata;
               k_q <= k_last ? '0 : k_q + 1'b1;
            end
            WR_DATA: if (bmem_ready) begin
               k_q <= k_last ? '0 : k_q + 1'b1;
            end
            RESP: begin
               last_q <= grant_q;
               k_q    <= '0;
            end
            default: ;
         endcase
      end
   end

   // A port raising read and write together is served as a write.
   always_ff @(posedge clk) begin
      if (!rst && state_q == IDLE)
         assert (!(|(dfp_read & dfp_write)));
   end

   assign dfp_rdata = line_q;

   always_comb begin
      bmem_read  = 1'b0;
      bmem_write = 1'b0;
      bmem_addr  = '0;
      bmem_wdata = '0;
      dfp_resp   = '0;
      unique case (state_q)
         RD_CMD: begin
            bmem_read = 1'b1;
            bmem_addr = addr_q;
         end
         WR_DATA: begin
            bmem_write = 1'b1;
            bmem_addr  = addr_q;
            bmem_wdata = wline_q[int'(k_q)*BUS_BITS +: BUS_BITS];
         end
         RESP:    dfp_resp[grant_q] = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_bmem_arbiter.sv
// Directed bench for bmem_arbiter: reads, writes with stalls, round-robin,
// address alignment, mid-line reset and stray rvalid.
module tb_bmem_arbiter;

   logic         clk = 1'b0;
   logic         rst;
   logic [63:0]  dfp_addr;
   logic [1:0]   dfp_read, dfp_write;
   logic [511:0] dfp_wdata;
   logic [255:0] dfp_rdata;
   logic [1:0]   dfp_resp;
   logic [31:0]  bmem_addr;
   logic         bmem_read, bmem_write;
   logic [63:0]  bmem_wdata;
   logic         bmem_ready;
   logic [31:0]  bmem_raddr;
   logic [63:0]  bmem_rdata;
   logic         bmem_rvalid;

   int tests = 0;
   int fails = 0;
   int accepted = 0;

   bmem_arbiter dut (
      .clk(clk), .rst(rst),
      .dfp_addr(dfp_addr), .dfp_read(dfp_read),
      .dfp_write(dfp_write), .dfp_wdata(dfp_wdata),
      .dfp_rdata(dfp_rdata), .dfp_resp(dfp_resp),
      .bmem_addr(bmem_addr), .bmem_read(bmem_read),
      .bmem_write(bmem_write), .bmem_wdata(bmem_wdata),
      .bmem_ready(bmem_ready), .bmem_raddr(bmem_raddr),
      .bmem_rdata(bmem_rdata), .bmem_rvalid(bmem_rvalid)
   );

   always #5 clk = ~clk;

   always @(posedge clk)
      if (bmem_write && bmem_ready) accepted++;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(string tag, logic [255:0] obs, logic [255:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [255:0] mk_line(logic [31:0] seed);
      logic [255:0] l;
      for (int i = 0; i < 4; i++)
         l[64*i +: 64] = {32'hA5000000 | seed, 32'(i)};
      return l;
   endfunction

   // Drives four read beats, LSB beat first; ends in the RESP cycle.
   task automatic feed_line(logic [255:0] l);
      for (int i = 0; i < 4; i++) begin
         bmem_rvalid = 1'b1;
         bmem_rdata  = l[64*i +: 64];
         tick();
      end
      bmem_rvalid = 1'b0;
      bmem_rdata  = '0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic chk_idle(string tag);
      chk({tag, "_rd"}, 256'(bmem_read), 256'd0);
      chk({tag, "_wr"}, 256'(bmem_write), 256'd0);
      chk({tag, "_addr"}, 256'(bmem_addr), 256'd0);
      chk({tag, "_wdata"}, 256'(bmem_wdata), 256'd0);
      chk({tag, "_resp"}, 256'(dfp_resp), 256'd0);
   endtask

   logic [255:0] la, lb, lc, w, w2, junk;

   initial begin
      dfp_addr    = '0;
      dfp_read    = '0;
      dfp_write   = '0;
      dfp_wdata   = '0;
      bmem_ready  = 1'b1;
      bmem_raddr  = '0;
      bmem_rdata  = '0;
      bmem_rvalid = 1'b0;
      la = mk_line(32'h11);
      lb = mk_line(32'h22);
      lc = mk_line(32'h33);
      w  = {64'hDDDD0003, 64'hCCCC0002, 64'hBBBB0001, 64'hAAAA0000};
      w2 = mk_line(32'h77);
      junk = {4{64'hDEADBEEFDEADBEEF}};

      do_reset();
      chk_idle("reset");
      chk("reset_rdata", dfp_rdata, 256'd0);

      // Single read on port 0
      dfp_addr[31:0] = 32'h1eceb000;
      dfp_read = 2'b01;
      tick();
      chk("rd_cmd", 256'(bmem_read), 256'd1);
      chk("rd_addr", 256'(bmem_addr), 256'h1eceb000);
      tick();
      chk("rd_pulse", 256'(bmem_read), 256'd0);
      feed_line(la);
      chk("rd_resp", 256'(dfp_resp), 256'b01);
      chk("rd_line", dfp_rdata, la);
      dfp_read = 2'b00;
      tick();
      chk("rd_resp_1cyc", 256'(dfp_resp), 256'b00);

      // Round-robin with both ports reading continuously
      do_reset();
      dfp_addr = {32'h00000200, 32'h00000100};
      dfp_read = 2'b11;
      for (int t = 0; t < 4; t++) begin
         tick();
         chk("rr_addr", 256'(bmem_addr), (t % 2 == 0) ? 256'h100 : 256'h200);
         tick();
         feed_line(mk_line(32'(t)));
         chk("rr_resp", 256'(dfp_resp), (t % 2 == 0) ? 256'b01 : 256'b10);
         chk("rr_line", dfp_rdata, mk_line(32'(t)));
         tick();
         chk("rr_gap", 256'(dfp_resp), 256'b00);
      end
      dfp_read = 2'b00;
      tick();

      // Port 1 write, ready low for 3 cycles on beat 2
      accepted = 0;
      dfp_addr[63:32] = 32'h00004000;
      dfp_wdata[511:256] = w;
      dfp_write = 2'b10;
      tick();
      chk("wr_valid", 256'(bmem_write), 256'd1);
      chk("wr_addr", 256'(bmem_addr), 256'h4000);
      chk("wr_b0", 256'(bmem_wdata), 256'(w[63:0]));
      tick();
      chk("wr_b1", 256'(bmem_wdata), 256'(w[127:64]));
      tick();
      chk("wr_b2", 256'(bmem_wdata), 256'(w[191:128]));
      bmem_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("wr_hold", 256'(bmem_wdata), 256'(w[191:128]));
         chk("wr_hold_v", 256'(bmem_write), 256'd1);
      end
      bmem_ready = 1'b1;
      tick();
      chk("wr_b3", 256'(bmem_wdata), 256'(w[255:192]));
      tick();
      chk("wr_resp", 256'(dfp_resp), 256'b10);
      chk("wr_done", 256'(bmem_write), 256'd0);
      chk("wr_rdata_kept", dfp_rdata, mk_line(32'd3));
      chk("wr_beats", 256'(accepted), 256'd4);
      dfp_write = 2'b00;
      tick();

      // Unaligned read, reset after two beats
      dfp_addr[31:0] = 32'h1eceb014;
      dfp_read = 2'b01;
      tick();
      chk("align_addr", 256'(bmem_addr), 256'h1eceb000);
      tick();
      bmem_rvalid = 1'b1;
      bmem_rdata = junk[63:0];
      tick();
      tick();
      bmem_rvalid = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk_idle("mid_rst");
      chk("mid_rst_rdata", dfp_rdata, 256'd0);
      tick();
      chk("post_rst_cmd", 256'(bmem_read), 256'd1);
      tick();
      feed_line(lb);
      chk("post_rst_resp", 256'(dfp_resp), 256'b01);
      chk("post_rst_line", dfp_rdata, lb);
      dfp_read = 2'b00;
      tick();

      // Stray rvalid in IDLE and in WR_DATA
      bmem_rvalid = 1'b1;
      bmem_rdata = junk[63:0];
      tick();
      tick();
      chk_idle("stray_idle");
      chk("stray_idle_rdata", dfp_rdata, lb);
      dfp_addr[31:0] = 32'h00008000;
      dfp_wdata[255:0] = w2;
      dfp_write = 2'b01;
      tick();
      chk("stray_wr_b0", 256'(bmem_wdata), 256'(w2[63:0]));
      for (int i = 0; i < 4; i++) tick();
      chk("stray_wr_resp", 256'(dfp_resp), 256'b01);
      chk("stray_wr_rdata", dfp_rdata, lb);
      bmem_rvalid = 1'b0;
      dfp_write = 2'b00;
      dfp_addr[63:32] = 32'h00000300;
      dfp_read = 2'b10;
      tick();
      tick();
      chk("clean_cmd", 256'(bmem_addr), 256'h300);
      tick();
      feed_line(lc);
      chk("clean_resp", 256'(dfp_resp), 256'b10);
      chk("clean_line", dfp_rdata, lc);
      dfp_read = 2'b00;
      tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
